// File: rtl/freq_meter_pkg.sv
// Shared definitions for the period meter: FSM encoding and default counter width.
// FREQ_METER_SYNC_EN (see sig_edge_sync) selects the 2-FF input synchroniser.
package freq_meter_pkg;

  localparam int FM_CNT_WIDTH = 16;

  typedef enum logic {
    FM_IDLE    = 1'b0,
    FM_MEASURE = 1'b1
  } fm_state_e;

endpackage

// File: rtl/freq_meter_sig_edge_sync.sv
// Rising-edge detector for sig_in. FREQ_METER_SYNC_EN inserts a 2-FF synchroniser
// ahead of the edge register so an asynchronous sig_in can be used.
module sig_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic sig_s;
  logic sig_d_q;

`ifdef FREQ_METER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], sig_in};
  end

  assign sig_s = sync_q[1];
`else
  assign sig_s = sig_in;
`endif

  // The edge register runs regardless of enable, so a level already high at enable is not a rise.
  always_ff @(posedge clk) begin
    if (rst) sig_d_q <= 1'b0;
    else     sig_d_q <= sig_s;
  end

  assign rise = sig_s & ~sig_d_q;

endmodule

// File: rtl/freq_meter.sv
// Period meter: counts clk cycles between consecutive rising edges of sig_in.
// Build with FREQ_METER_SYNC_EN for an asynchronous sig_in (adds 2 cycles of latency).
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_WIDTH = FM_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 overflow,
  output logic                 busy
);

  logic                 rise;
  fm_state_e            state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] period_q;
  logic                 period_valid_q;
  logic                 overflow_q;

  sig_edge_sync u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise)
  );

  // Priority in MEASURE: enable drop, then rise, then counter saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FM_IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      case (state_q)
        FM_IDLE: begin
          cnt_q <= '0;
          if (enable && rise) begin
            state_q <= FM_MEASURE;
            cnt_q   <= CNT_WIDTH'(1);
          end
        end
        FM_MEASURE: begin
          if (!enable) begin
            state_q <= FM_IDLE;
            cnt_q   <= '0;
          end else if (rise) begin
            period_q       <= cnt_q;
            period_valid_q <= 1'b1;
            cnt_q          <= CNT_WIDTH'(1);
          end else if (&cnt_q) begin
            overflow_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= FM_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= FM_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q == FM_MEASURE);

endmodule
